// File: rtl/mmio_timer_gpio.sv
// Memory-mapped GPIO + 32-bit compare timer + scratch register, one-cycle registered read path.
// Optional PRESCALER_EN macro turns offset 0x1C into a 16-bit timer prescaler (TIMER_PRE).
module mmio_timer_gpio #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          GPIO_W    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CS,
    input  logic              WR_RD,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       Data_BUS_WRITE,
    output logic [31:0]       Data_BUS_READ,
    input  logic [GPIO_W-1:0] GPIO_IN,
    output logic [GPIO_W-1:0] GPIO_OUT,
    output logic              IRQ
);

    typedef enum logic [2:0] {
        SEL_GPIO_OUT = 3'd0,
        SEL_GPIO_IN  = 3'd1,
        SEL_CNT      = 3'd2,
        SEL_CMP      = 3'd3,
        SEL_CTRL     = 3'd4,
        SEL_STAT     = 3'd5,
        SEL_SCRATCH  = 3'd6,
        SEL_PRE      = 3'd7
    } sel_e;

    logic              hit, wr_en, rd_en;
    sel_e              sel;
    logic              unused_addr_bits;

    logic [GPIO_W-1:0] gpio_out_q;
    logic [GPIO_W-1:0] sync_meta_q, sync_q;
    logic [31:0]       cnt_q, cmp_q, scratch_q, rdata_q;
    logic [2:0]        ctrl_q;
    logic              match_q, irq_q;

    logic              cnt_wr, tick, cmp_hit, stat_clr, match_d;
    logic [31:0]       cnt_d, rd_mux;

`ifdef PRESCALER_EN
    logic [15:0]       pre_q, psc_q;
`endif

    assign hit              = CS && (ADDR[31:5] == BASE_ADDR[31:5]);
    assign wr_en            = hit && WR_RD;
    assign rd_en            = hit && !WR_RD;
    assign sel              = sel_e'(ADDR[4:2]);
    assign unused_addr_bits = ^ADDR[1:0];

    assign cnt_wr   = wr_en && (sel == SEL_CNT);
    assign stat_clr = wr_en && (sel == SEL_STAT) && Data_BUS_WRITE[0];

`ifdef PRESCALER_EN
    assign tick = ctrl_q[0] && (psc_q == pre_q);
`else
    assign tick = ctrl_q[0];
`endif

    // A software CNT write suppresses both the tick and the compare in that cycle.
    assign cmp_hit = tick && !cnt_wr && (cnt_q == cmp_q);
    assign match_d = cmp_hit || (match_q && !stat_clr);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cnt_d = cnt_q;
        if (cnt_wr)
            cnt_d = Data_BUS_WRITE;
        else if (cmp_hit && ctrl_q[1])
            cnt_d = '0;
        else if (tick)
            cnt_d = cnt_q + 32'd1;
    end

    always_comb begin
        rd_mux = '0;
        unique case (sel)
            SEL_GPIO_OUT: rd_mux[GPIO_W-1:0] = gpio_out_q;
            SEL_GPIO_IN:  rd_mux[GPIO_W-1:0] = sync_q;
            SEL_CNT:      rd_mux = cnt_q;
            SEL_CMP:      rd_mux = cmp_q;
            SEL_CTRL:     rd_mux[2:0] = ctrl_q;
            SEL_STAT:     rd_mux[0] = match_q;
            SEL_SCRATCH:  rd_mux = scratch_q;
`ifdef PRESCALER_EN
            SEL_PRE:      rd_mux[15:0] = pre_q;
`else
            SEL_PRE:      rd_mux = '0;
`endif
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!RST) begin
            gpio_out_q  <= '0;
            sync_meta_q <= '0;
            sync_q      <= '0;
            cnt_q       <= '0;
            cmp_q       <= '0;
            ctrl_q      <= '0;
            match_q     <= 1'b0;
            scratch_q   <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
`ifdef PRESCALER_EN
            pre_q       <= '0;
            psc_q       <= '0;
`endif
        end else begin
            sync_meta_q <= GPIO_IN;
            sync_q      <= sync_meta_q;
            rdata_q     <= rd_en ? rd_mux : 32'd0;
            cnt_q       <= cnt_d;
            match_q     <= match_d;
            irq_q       <= match_d && ctrl_q[2];

            if (wr_en) begin
                case (sel)
                    SEL_GPIO_OUT: gpio_out_q <= Data_BUS_WRITE[GPIO_W-1:0];
                    SEL_CMP:      cmp_q      <= Data_BUS_WRITE;
                    SEL_CTRL:     ctrl_q     <= Data_BUS_WRITE[2:0];
                    SEL_SCRATCH:  scratch_q  <= Data_BUS_WRITE;
`ifdef PRESCALER_EN
                    SEL_PRE:      pre_q      <= Data_BUS_WRITE[15:0];
`endif
                    default: ;
                endcase
            end

`ifdef PRESCALER_EN
            if (cnt_wr || !ctrl_q[0] || (psc_q == pre_q))
                psc_q <= '0;
            else
                psc_q <= psc_q + 16'd1;
`endif
        end
    end

    assign Data_BUS_READ = rdata_q;
    assign GPIO_OUT      = gpio_out_q;
    assign IRQ           = irq_q;

endmodule

// File: tb/tb_mmio_timer_gpio.sv
// Self-checking bench for mmio_timer_gpio: directed scenarios plus randomized bus traffic
// compared every cycle against a register-array reference model.
module tb_mmio_timer_gpio;

    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam int          GW   = 8;
    localparam logic [31:0] GMASK = 32'((64'd1 << GW) - 64'd1);

    logic          clk = 1'b0;
    logic          rst, cs, wr_rd;
    logic [31:0]   addr, wdata, rdata;
    logic [GW-1:0] gin, gout;
    logic          irq;

    always #5 clk = ~clk;

    mmio_timer_gpio #(.BASE_ADDR(BASE), .GPIO_W(GW)) dut (
        .CLK(clk), .RST(rst), .CS(cs), .WR_RD(wr_rd), .ADDR(addr),
        .Data_BUS_WRITE(wdata), .Data_BUS_READ(rdata),
        .GPIO_IN(gin), .GPIO_OUT(gout), .IRQ(irq)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: word-indexed register file plus match flag, sync pipe and prescale count.
    logic [31:0]   m_reg [8];
    logic          m_match, m_irq;
    logic [GW-1:0] m_sync [2];
    logic [31:0]   m_rdata;
    logic [15:0]   m_psc;

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            1:       return 32'(m_sync[1]);
            5:       return {31'd0, m_match};
`ifdef PRESCALER_EN
            7:       return m_reg[7];
`else
            7:       return 32'd0;
`endif
            default: return m_reg[idx];
        endcase
    endfunction

    task automatic model_step();
        logic hit, wr, en, tick, cnt_wr, fire, new_match;
        logic [31:0] rd, new_cnt;
        int idx;
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
            m_match = 1'b0; m_irq = 1'b0; m_rdata = 32'd0; m_psc = 16'd0;
            m_sync[0] = '0; m_sync[1] = '0;
            return;
        end
        hit    = cs && ((addr >> 5) == (BASE >> 5));
        wr     = hit && wr_rd;
        idx    = int'((addr >> 2) & 32'd7);
        rd     = (hit && !wr_rd) ? m_read(idx) : 32'd0;
        en     = m_reg[4][0];
`ifdef PRESCALER_EN
        tick   = en && (m_psc == m_reg[7][15:0]);
`else
        tick   = en;
`endif
        cnt_wr = wr && (idx == 2);
        fire   = tick && !cnt_wr && (m_reg[2] == m_reg[3]);
        if (cnt_wr)                 new_cnt = wdata;
        else if (!tick)             new_cnt = m_reg[2];
        else if (fire && m_reg[4][1]) new_cnt = 32'd0;
        else                        new_cnt = m_reg[2] + 32'd1;
        new_match = fire || (m_match && !(wr && idx == 5 && wdata[0]));
        m_psc = (cnt_wr || !en || tick) ? 16'd0 : m_psc + 16'd1;
        m_irq = new_match && m_reg[4][2];
        if (wr) begin
            case (idx)
                0: m_reg[0] = wdata & GMASK;
                3: m_reg[3] = wdata;
                4: m_reg[4] = wdata & 32'd7;
                6: m_reg[6] = wdata;
                7: m_reg[7] = wdata & 32'h0000_FFFF;
                default: ;
            endcase
        end
        m_reg[2] = new_cnt;
        m_match  = new_match;
        m_rdata  = rd;
        m_sync[1] = m_sync[0];
        m_sync[0] = gin;
    endtask

    task automatic cycle(input logic r, input logic c, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        rst = r; cs = c; wr_rd = w; addr = a; wdata = d;
        model_step();
        @(posedge clk);
        #1;
        check("rdata", rdata, m_rdata);
        check("gpio_out", 32'(gout), m_reg[0]);
        check("irq", 32'(irq), 32'(m_irq));
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
        cycle(1'b1, 1'b1, 1'b1, BASE + off, d);
    endtask

    task automatic rd_reg(input logic [31:0] off);
        cycle(1'b1, 1'b1, 1'b0, BASE + off, 32'd0);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic r, c, w;
        logic [31:0] a, d, off;

        rst = 1'b0; cs = 1'b0; wr_rd = 1'b0; addr = '0; wdata = '0; gin = '0;
        @(negedge clk);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, BASE, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_gpio", 32'(gout), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_reg(32'(i * 4));
            check("rst_read", rdata, 32'd0);
        end

        // Scratch and GPIO_OUT write/readback
        wr_reg(32'h18, 32'hDEAD_BEEF);
        wr_reg(32'h00, 32'h0000_00A5);
        rd_reg(32'h18);
        check("scratch_rb", rdata, 32'hDEAD_BEEF);
        rd_reg(32'h00);
        check("gpio_rb", rdata, 32'h0000_00A5);
        check("gpio_pin", 32'(gout), 32'h0000_00A5);

        // Misses: CS low at BASE, CS high one window above
        cycle(1'b1, 1'b0, 1'b1, BASE + 32'h18, 32'h1234_5678);
        cycle(1'b1, 1'b1, 1'b1, BASE + 32'h38, 32'h1111_1111);
        cycle(1'b1, 1'b1, 1'b0, BASE + 32'h20, 32'd0);
        check("miss_rd", rdata, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, BASE + 32'h18, 32'd0);
        check("nocs_rd", rdata, 32'd0);
        rd_reg(32'h18);
        check("miss_nochg", rdata, 32'hDEAD_BEEF);

        // Auto-clear compare timer with IRQ, period 6
        wr_reg(32'h0C, 32'd5);
        wr_reg(32'h08, 32'd0);
        wr_reg(32'h10, 32'd7);
        repeat (5) idle();
        check("irq_early", 32'(irq), 32'd0);
        idle();
        check("irq_match", 32'(irq), 32'd1);
        wr_reg(32'h14, 32'd1);
        check("irq_clr", 32'(irq), 32'd0);
        repeat (4) idle();
        wr_reg(32'h14, 32'd1);
        check("set_wins", 32'(irq), 32'd1);
        rd_reg(32'h14);
        check("match_kept", rdata, 32'd1);

        // Free-running wrap without auto-clear
        wr_reg(32'h10, 32'd0);
        wr_reg(32'h14, 32'd1);
        wr_reg(32'h0C, 32'd3);
        wr_reg(32'h08, 32'hFFFF_FFFE);
        wr_reg(32'h10, 32'd1);
        idle();
        idle();
        rd_reg(32'h14);
        check("wrap_nomatch", rdata, 32'd0);
        rd_reg(32'h08);
        check("wrap_cnt", rdata, 32'd1);
        idle();
        idle();
        rd_reg(32'h14);
        check("wrap_match", rdata, 32'd1);
        wr_reg(32'h08, 32'h0000_0100);
        rd_reg(32'h08);
        check("cnt_wr_wins", rdata, 32'h0000_0100);
        rd_reg(32'h08);
        check("cnt_after_wr", rdata, 32'h0000_0101);

        // GPIO_IN synchronizer latency
        idle();
        idle();
        gin = 8'h3C;
        rd_reg(32'h04);
        check("gin_lat0", rdata, 32'd0);
        rd_reg(32'h04);
        check("gin_lat1", rdata, 32'd0);
        rd_reg(32'h04);
        check("gin_lat2", rdata, 32'h0000_003C);

`ifdef PRESCALER_EN
        wr_reg(32'h10, 32'd0);
        wr_reg(32'h1C, 32'd3);
        wr_reg(32'h08, 32'd0);
        wr_reg(32'h10, 32'd1);
        repeat (4) idle();
        rd_reg(32'h08);
        check("pre_cnt1", rdata, 32'd1);
        repeat (3) idle();
        rd_reg(32'h08);
        check("pre_cnt2", rdata, 32'd2);
        rd_reg(32'h1C);
        check("pre_rb", rdata, 32'd3);
`endif

        // Randomized traffic against the model, with occasional mid-run resets
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) != 0);
            c   = ($urandom_range(0, 9) != 0);
            w   = 1'($urandom_range(0, 1));
            off = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            a   = ($urandom_range(0, 15) == 0) ? $urandom : BASE + off;
            case (off >> 2)
                32'd2, 32'd3: d = 32'($urandom_range(0, 12));
                32'd7:        d = 32'($urandom_range(0, 3));
                default:      d = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) gin = GW'($urandom);
            cycle(r, c, w, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
